// File: rtl/test_rd_check_v1_0.sv
// AXI read-side checker: issues one read burst per read_en request, checks every R beat
// against an address-derived pattern, and keeps sticky error status and a saturating count.
module test_rd_check_v1_0 #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int AXI_DW          = 128,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       read_en,
  input  logic [CTRL_ADDR_WIDTH-1:0] rw_addr,
  input  logic [3:0]                 rw_id,
  input  logic [3:0]                 rw_len,
  input  logic                       err_clr,
  output logic                       read_done_p,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]                 axi_arid,
  output logic [3:0]                 axi_arlen,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,
  input  logic [AXI_DW-1:0]          axi_rdata,
  input  logic [3:0]                 axi_rid,
  input  logic                       axi_rlast,
  input  logic                       axi_rvalid,
  output logic                       axi_rready,
  output logic                       err_flag,
  output logic                       id_err,
  output logic                       len_err,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  output logic [CTRL_ADDR_WIDTH-1:0] last_err_addr
);

  localparam int N_WORDS = AXI_DW / 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                 r_state;
  logic [CTRL_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                 r_id;
  logic [3:0]                 r_len;
  logic [4:0]                 r_beat;
  logic                       r_err_flag;
  logic                       r_id_err;
  logic                       r_len_err;
  logic [ERR_CNT_W-1:0]       r_err_cnt;
  logic [CTRL_ADDR_WIDTH-1:0] r_last_err_addr;

  logic                 w_beat;
  logic [31:0]          w_exp_word;
  logic [AXI_DW-1:0]    w_exp_beat;
  logic                 w_data_bad;
  logic                 w_id_bad;
  logic                 w_len_bad;
  logic                 w_at_len;
  logic [ERR_CNT_W-1:0] w_cnt_inc;

  // Expected word is the zero-extended start address plus the (saturated) beat index.
  assign w_beat     = (r_state == S_DATA) && axi_rvalid;
  assign w_exp_word = 32'(r_addr) + 32'(r_beat);
  assign w_exp_beat = {N_WORDS{w_exp_word}};
  assign w_at_len   = (r_beat == {1'b0, r_len});
  assign w_data_bad = w_beat && (axi_rdata != w_exp_beat);
  assign w_id_bad   = w_beat && (axi_rid != r_id);
  assign w_len_bad  = w_beat && (axi_rlast ? !w_at_len : w_at_len);
  assign w_cnt_inc  = (&r_err_cnt) ? r_err_cnt : r_err_cnt + ERR_CNT_W'(1);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (read_en) begin
            r_addr  <= rw_addr;
            r_id    <= rw_id;
            r_len   <= rw_len;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi_arready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (axi_rvalid) begin
            if (axi_rlast) begin
              r_beat  <= '0;
              r_state <= S_DONE;
            end else if (r_beat != 5'd31) begin
              r_beat <= r_beat + 5'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A detected error in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag      <= 1'b0;
      r_id_err        <= 1'b0;
      r_len_err       <= 1'b0;
      r_err_cnt       <= '0;
      r_last_err_addr <= '0;
    end else begin
      if (w_data_bad) begin
        r_err_flag      <= 1'b1;
        r_err_cnt       <= err_clr ? ERR_CNT_W'(1) : w_cnt_inc;
        r_last_err_addr <= r_addr;
      end else if (err_clr) begin
        r_err_flag <= 1'b0;
        r_err_cnt  <= '0;
      end

      if (w_id_bad)     r_id_err <= 1'b1;
      else if (err_clr) r_id_err <= 1'b0;

      if (w_len_bad)    r_len_err <= 1'b1;
      else if (err_clr) r_len_err <= 1'b0;
    end
  end

  assign axi_araddr    = r_addr;
  assign axi_arid      = r_id;
  assign axi_arlen     = r_len;
  assign axi_arvalid   = (r_state == S_ADDR);
  assign axi_rready    = (r_state == S_DATA);
  assign read_done_p   = (r_state == S_DONE);
  assign err_flag      = r_err_flag;
  assign id_err        = r_id_err;
  assign len_err       = r_len_err;
  assign err_cnt       = r_err_cnt;
  assign last_err_addr = r_last_err_addr;

endmodule
